// File: rtl/tlc_multi_dir.sv
// Multi-direction traffic-light controller: one green at a time, sensor-driven skipping, parade hold.
// Optional pedestrian walk phase is compiled in with `define TLC_PED_EN.
module tlc_multi_dir #(
  parameter int NUM_DIR    = 4,
  parameter int TMR_W      = 8,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 16,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int PARADE_DIR = 1,
  parameter int WALK_CYC   = 6
) (
  input  logic                       c_clk,
  input  logic                       c_rst,
  input  logic [NUM_DIR-1:0]         c_t,
  input  logic                       c_p,
  input  logic                       c_r,
  output logic [2*NUM_DIR-1:0]       c_l,
  output logic                       c_m,
  output logic [$clog2(NUM_DIR)-1:0] c_cur_dir
`ifdef TLC_PED_EN
  ,
  input  logic                       c_ped_req,
  output logic                       c_walk
`endif
);

  localparam int DIR_W = $clog2(NUM_DIR);
  localparam logic [TMR_W-1:0] GMIN_LAST = TMR_W'(GREEN_MIN - 1);
  localparam logic [TMR_W-1:0] GMAX_LAST = TMR_W'(GREEN_MAX - 1);
  localparam logic [TMR_W-1:0] Y_LAST    = TMR_W'(YELLOW_CYC - 1);
  localparam logic [TMR_W-1:0] AR_LAST   = TMR_W'(ALLRED_CYC - 1);
  localparam logic [DIR_W-1:0] PAR_DIR   = DIR_W'(PARADE_DIR);
`ifdef TLC_PED_EN
  localparam logic [TMR_W-1:0] W_LAST    = TMR_W'(WALK_CYC - 1);
`endif

  if (NUM_DIR < 2 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_CYC < 1 ||
      ALLRED_CYC < 1 || PARADE_DIR >= NUM_DIR || WALK_CYC < 1) begin : g_param_chk
    $error("tlc_multi_dir: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_WALK} state_t;

  state_t            state_q;
  logic [DIR_W-1:0]  cur_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              mode_q;
  logic [TMR_W-1:0]  tmr_inc;
  logic              hold;
  logic              green_done;
  logic [DIR_W-1:0]  next_dir;
`ifdef TLC_PED_EN
  logic              ped_q;
`endif

  // Round-robin search starting after cur; cur itself is the last candidate.
  function automatic logic [DIR_W-1:0] pick_dir(input logic [DIR_W-1:0] cur,
                                                input logic [NUM_DIR-1:0] t,
                                                input logic m);
    logic [DIR_W-1:0] idx;
    logic             found;
    pick_dir = DIR_W'((int'(cur) + 1) % NUM_DIR);
    found    = 1'b0;
    if (m) begin
      pick_dir = PAR_DIR;
    end else begin
      for (int k = 1; k <= NUM_DIR; k++) begin
        idx = DIR_W'((int'(cur) + k) % NUM_DIR);
        if (!found && t[idx]) begin
          pick_dir = idx;
          found    = 1'b1;
        end
      end
    end
  endfunction

  assign tmr_inc    = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
  assign hold       = mode_q && (cur_q == PAR_DIR);
  // Max-green compare is >= so a green released from a saturated parade hold still exits.
  assign green_done = !hold && (tmr_q >= GMIN_LAST) &&
                      (!c_t[cur_q] || (tmr_q >= GMAX_LAST) || mode_q);
  assign next_dir   = pick_dir(cur_q, c_t, mode_q);

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state_q <= S_GREEN;
      cur_q   <= '0;
      tmr_q   <= '0;
      mode_q  <= 1'b0;
`ifdef TLC_PED_EN
      ped_q   <= 1'b0;
`endif
    end else begin
      mode_q <= c_r ? 1'b0 : (c_p ? 1'b1 : mode_q);
      tmr_q  <= tmr_inc;
`ifdef TLC_PED_EN
      if (c_ped_req) ped_q <= 1'b1;
`endif
      unique case (state_q)
        S_GREEN: begin
          if (green_done) begin
            state_q <= S_YELLOW;
            tmr_q   <= '0;
          end
        end
        S_YELLOW: begin
          if (tmr_q == Y_LAST) begin
            state_q <= S_ALLRED;
            tmr_q   <= '0;
          end
        end
        S_ALLRED: begin
          if (tmr_q == AR_LAST) begin
            tmr_q <= '0;
`ifdef TLC_PED_EN
            if (ped_q) begin
              state_q <= S_WALK;
              ped_q   <= 1'b0;
            end else
`endif
            begin
              state_q <= S_GREEN;
              cur_q   <= next_dir;
            end
          end
        end
`ifdef TLC_PED_EN
        S_WALK: begin
          if (tmr_q == W_LAST) begin
            state_q <= S_GREEN;
            cur_q   <= next_dir;
            tmr_q   <= '0;
          end
        end
`endif
        default: begin
          state_q <= S_GREEN;
          tmr_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    c_l = '1;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (cur_q == DIR_W'(i)) begin
        if (state_q == S_GREEN)       c_l[2*i +: 2] = 2'b00;
        else if (state_q == S_YELLOW) c_l[2*i +: 2] = 2'b01;
      end
    end
  end

  assign c_m       = mode_q;
  assign c_cur_dir = cur_q;
`ifdef TLC_PED_EN
  assign c_walk    = (state_q == S_WALK);
`endif

endmodule
